// File: rtl/sqrt_pkg.sv
// Shared types for the sequential integer square root.
// State encoding and remainder width helper.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int rem_w(input int asize);
        return asize / 2 + 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: tries bit i of the root
// and subtracts its contribution from the partial remainder.
module sqrt_step #(
    parameter int ASIZE = 8,
    localparam int N = ASIZE / 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]     v,
    input  logic [ASIZE-1:0] r,
    input  logic [IW-1:0]    i,
    output logic [N-1:0]     v_nxt,
    output logic [ASIZE-1:0] r_nxt
);

    logic [ASIZE-1:0] tt;
    logic [IW:0]      sh_v;
    logic [IW:0]      sh_b;

    always_comb begin
        sh_v  = {1'b0, i} + 1'b1;
        sh_b  = {i, 1'b0};
        // (2v + 2^i) * 2^i, the growth of v^2 when bit i is set
        tt    = (ASIZE'(v) << sh_v) | (ASIZE'(1) << sh_b);
        v_nxt = v;
        r_nxt = r;
        if (tt <= r) begin
            v_nxt = v | (N'(1) << i);
            r_nxt = r - tt;
        end
    end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential integer square root, one root bit per cycle,
// valid/ready on both sides, optional round-to-nearest.
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int ASIZE = 8,
    parameter int ROUND = 0,
    localparam int N = ASIZE / 2,
    localparam int RW = rem_w(ASIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ASIZE-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     z,
    output logic [RW-1:0]    rem
);

    localparam int IW = $clog2(N);
    localparam logic [N-1:0] VMAX = '1;

    state_t           state;
    logic [ASIZE-1:0] r;
    logic [ASIZE-1:0] r_nxt;
    logic [N-1:0]     v;
    logic [N-1:0]     v_nxt;
    logic [IW-1:0]    i;
    logic [N-1:0]     z_fin;

    sqrt_step #(.ASIZE(ASIZE)) u_step (
        .v     (v),
        .r     (r),
        .i     (i),
        .v_nxt (v_nxt),
        .r_nxt (r_nxt)
    );

    // a - v^2 > v means a >= (v + 0.5)^2 for integers
    always_comb begin
        z_fin = v_nxt;
        if (ROUND != 0 && v_nxt != VMAX && r_nxt[N:0] > {1'b0, v_nxt})
            z_fin = v_nxt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            rem       <= '0;
            r         <= '0;
            v         <= '0;
            i         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        r        <= a;
                        v        <= '0;
                        i        <= IW'(N - 1);
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    v <= v_nxt;
                    r <= r_nxt;
                    if (i == '0) begin
                        z         <= z_fin;
                        rem       <= r_nxt[N:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        i <= i - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed and swept checks of sqrt_seq: floor and rounded
// 8-bit variants side by side, plus a 16-bit floor variant.
module tb_sqrt_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a8 = '0;
    logic       iv8 = 1'b0;
    logic       or8 = 1'b0;
    logic       ir_f, ov_f, ir_r, ov_r;
    logic [3:0] z_f, z_r;
    logic [4:0] rem_f, rem_r;

    logic [15:0] a16 = '0;
    logic        iv16 = 1'b0;
    logic        or16 = 1'b0;
    logic        ir16, ov16;
    logic [7:0]  z16;
    logic [8:0]  rem16;

    int n_chk = 0;
    int n_bad = 0;

    sqrt_seq #(.ASIZE(8), .ROUND(0)) u_f (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir_f), .a(a8),
        .out_valid(ov_f), .out_ready(or8), .z(z_f), .rem(rem_f)
    );

    sqrt_seq #(.ASIZE(8), .ROUND(1)) u_r (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir_r), .a(a8),
        .out_valid(ov_r), .out_ready(or8), .z(z_r), .rem(rem_r)
    );

    sqrt_seq #(.ASIZE(16), .ROUND(0)) u_w (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16),
        .out_valid(ov16), .out_ready(or16), .z(z16), .rem(rem16)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int s = 0;
        for (int k = 0; k < 256; k++)
            if (k * k <= x) s = k;
        return s;
    endfunction

    task automatic do8(input logic [7:0] av, input logic [3:0] ezf,
                       input logic [3:0] ezr, input logic [4:0] erem,
                       input int hold);
        int t = 0;
        int lat = 0;
        while (!ir_f && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!ir_f) chk("rdy8_to", ir_f, 1);
        @(negedge clk);
        a8 = av; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'hA5;
        while (!ov_f && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("lat8", lat, 4);
        chk("ov_r", ov_r, 1);
        chk("z_floor", z_f, ezf);
        chk("z_round", z_r, ezr);
        chk("rem_floor", rem_f, erem);
        chk("rem_round", rem_r, erem);
        for (int k = 0; k < hold; k++) begin
            iv8 = k[0];
            @(posedge clk); #1;
            chk("hold_ov", ov_f, 1);
            chk("hold_z", z_f, ezf);
            chk("hold_rem", rem_f, erem);
            chk("hold_rdy", ir_f, 0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("rel_ov", ov_f, 0);
        chk("rel_rdy", ir_f, 1);
    endtask

    task automatic do16(input logic [15:0] av, input logic [7:0] ez,
                        input logic [8:0] erem);
        int t = 0;
        int lat = 0;
        while (!ir16 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!ir16) chk("rdy16_to", ir16, 1);
        a16 = av; iv16 = 1'b1; or16 = 1'b0;
        @(posedge clk); #1;
        iv16 = 1'b0;
        while (!ov16 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("lat16", lat, 8);
        chk("z16", z16, ez);
        chk("rem16", rem16, erem);
        t = 0;
        while (ov16 && t < 60) begin
            or16 = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1; t++;
        end
        or16 = 1'b0;
        chk("rel16", ov16, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int x;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", ir_f, 0);
        chk("rst_ov", ov_f, 0);
        chk("rst_z", z_f, 0);
        chk("rst_rem", rem_f, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdy", ir_f, 1);
        chk("post_rst_rdy16", ir16, 1);

        do8(8'd144, 4'd12, 4'd12, 5'd0, 0);
        do8(8'd0, 4'd0, 4'd0, 5'd0, 0);
        do8(8'd255, 4'd15, 4'd15, 5'd30, 0);
        do8(8'd156, 4'd12, 4'd12, 5'd12, 10);
        do8(8'd8, 4'd2, 4'd3, 5'd4, 0);
        do8(8'd6, 4'd2, 4'd2, 5'd2, 0);
        do8(8'd157, 4'd12, 4'd13, 5'd13, 0);

        @(negedge clk);
        a8 = 8'd200; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ov", ov_f, 0);
        chk("mid_rst_rdy", ir_f, 0);
        chk("mid_rst_z", z_f, 0);
        chk("mid_rst_rem", rem_f, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_idle", ir_f, 1);
        do8(8'd49, 4'd7, 4'd7, 5'd0, 0);

        do16(16'd65535, 8'd255, 9'd510);
        do16(16'd0, 8'd0, 9'd0);
        do16(16'd65024, 8'd254, 9'd508);
        for (int k = 0; k < 1500; k++) begin
            x = $urandom_range(0, 65535);
            do16(16'(x), 8'(isqrt(x)), 9'(x - isqrt(x) * isqrt(x)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
